dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory access interface: the other end of the wr/rd/addr/wr_data/rd_data traffic the core initiates.
- Accepts one load or store per handshake and stalls for a programmable number of wait states.
- Performs byte, half or word access into a 512-byte local RAM, then returns a single-cycle response with extended load data or a misalignment error.
- Sits between the core's datapath memory port and the data RAM; replaces the zero-latency data memory for wait-state and alignment testing.

---
 rtl/dmem_responder_if.sv | 28 ++
 rtl/dmem_responder.sv | 204 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between a core data-memory port and its responder.
// One request per handshake; a one-cycle response strobe comes back later.
interface dmem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, req_size, req_unsigned,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, req_size, req_unsigned,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: 512 B RAM with byte/half/word access, optional DMEM_STATS_EN counters.
// Latency: response strobe WAIT_CYCLES+1 cycles after the accept cycle.
// Backpressure: req_ready only in IDLE, so requests are spaced at least WAIT_CYCLES+2 cycles.
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               reset,
    dmem_responder_if.slave    bus
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]        stat_loads,
    output logic [15:0]        stat_stores,
    output logic [15:0]        stat_errs
`endif
);

    localparam int         WORDS     = 1 << (ADDR_W - 2);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                ready_q, busy_q, rsp_valid_q, rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;

    logic                l_wr, l_uns;
    logic [ADDR_W-1:0]   l_addr;
    logic [DATA_W-1:0]   l_wdata;
    logic [1:0]          l_size;

    logic [DATA_W-1:0]   mem [WORDS];

    // Access fields: live inputs when committing straight out of IDLE, latched copy otherwise.
    logic                a_wr, a_uns;
    logic [ADDR_W-1:0]   a_addr;
    logic [DATA_W-1:0]   a_wdata;
    logic [1:0]          a_size;

    logic                accept, enter_resp, misalign;
    logic [DATA_W-1:0]   rd_word, rd_shift, load_val, wlane;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;
    logic [3:0]          be;

    always_comb begin
        a_wr    = l_wr;
        a_uns   = l_uns;
        a_addr  = l_addr;
        a_wdata = l_wdata;
        a_size  = l_size;
        if (state == IDLE) begin
            a_wr    = bus.req_wr;
            a_uns   = bus.req_unsigned;
            a_addr  = bus.req_addr;
            a_wdata = bus.req_wdata;
            a_size  = bus.req_size;
        end
    end

    assign accept     = (state == IDLE) && ready_q && bus.req_valid;
    assign enter_resp = (accept && NO_WAIT) || ((state == WAIT) && (cnt == 4'd0));

    always_comb begin
        misalign = 1'b0;
        case (a_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = a_addr[0];
            2'b10:   misalign = (a_addr[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    assign rd_word  = mem[a_addr[ADDR_W-1:2]];
    assign rd_shift = rd_word >> {a_addr[1:0], 3'b000};
    assign byte_v   = rd_shift[7:0];
    assign half_v   = a_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        case (a_size)
            2'b00:   load_val = a_uns ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   load_val = a_uns ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        be    = 4'b1111;
        wlane = a_wdata;
        case (a_size)
            2'b00: begin
                be    = 4'b0001 << a_addr[1:0];
                wlane = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be    = a_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{a_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = a_wdata;
            end
        endcase
    end

    // RAM is never cleared; a reset forces IDLE with ready low, so enter_resp cannot fire.
    always_ff @(posedge clk) begin
        if (enter_resp && a_wr && !misalign) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[a_addr[ADDR_W-1:2]][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            l_wr        <= 1'b0;
            l_uns       <= 1'b0;
            l_addr      <= '0;
            l_wdata     <= '0;
            l_size      <= 2'b00;
        end else begin
            rsp_valid_q <= enter_resp;
            rsp_err_q   <= enter_resp && misalign;
            rsp_rdata_q <= (enter_resp && !misalign && !a_wr) ? load_val : '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        l_wr    <= bus.req_wr;
                        l_uns   <= bus.req_unsigned;
                        l_addr  <= bus.req_addr;
                        l_wdata <= bus.req_wdata;
                        l_size  <= bus.req_size;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (NO_WAIT) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                WAIT: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

`ifdef DMEM_STATS_EN
    // Counted while the response is on the bus; the latched request says what it was.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_loads  <= 16'd0;
            stat_stores <= 16'd0;
            stat_errs   <= 16'd0;
        end else if (state == RESP) begin
            if (rsp_err_q) begin
                if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
            end else if (l_wr) begin
                if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
            end else begin
                if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with WAIT_CYCLES = 0, 1 and 3.
module tb_dmem_responder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.DATA_W(32), .ADDR_W(9)) if0 ();
    dmem_responder_if #(.DATA_W(32), .ADDR_W(9)) if1 ();
    dmem_responder_if #(.DATA_W(32), .ADDR_W(9)) if2 ();

    // Per-instance drive/observe arrays; index 0 -> WAIT 0, 1 -> WAIT 1, 2 -> WAIT 3
    logic        d_valid [3];
    logic        d_wr    [3];
    logic [8:0]  d_addr  [3];
    logic [31:0] d_wdata [3];
    logic [1:0]  d_size  [3];
    logic        d_uns   [3];
    logic        o_ready [3];
    logic        o_rv    [3];
    logic [31:0] o_rdata [3];
    logic        o_err   [3];
    logic        o_busy  [3];

`ifdef DMEM_STATS_EN
    logic [15:0] s_loads [3];
    logic [15:0] s_stores[3];
    logic [15:0] s_errs  [3];
`endif

    assign if0.req_valid = d_valid[0]; assign if1.req_valid = d_valid[1]; assign if2.req_valid = d_valid[2];
    assign if0.req_wr    = d_wr[0];    assign if1.req_wr    = d_wr[1];    assign if2.req_wr    = d_wr[2];
    assign if0.req_addr  = d_addr[0];  assign if1.req_addr  = d_addr[1];  assign if2.req_addr  = d_addr[2];
    assign if0.req_wdata = d_wdata[0]; assign if1.req_wdata = d_wdata[1]; assign if2.req_wdata = d_wdata[2];
    assign if0.req_size  = d_size[0];  assign if1.req_size  = d_size[1];  assign if2.req_size  = d_size[2];
    assign if0.req_unsigned = d_uns[0]; assign if1.req_unsigned = d_uns[1]; assign if2.req_unsigned = d_uns[2];

    assign o_ready[0] = if0.req_ready; assign o_ready[1] = if1.req_ready; assign o_ready[2] = if2.req_ready;
    assign o_rv[0]    = if0.rsp_valid; assign o_rv[1]    = if1.rsp_valid; assign o_rv[2]    = if2.rsp_valid;
    assign o_rdata[0] = if0.rsp_rdata; assign o_rdata[1] = if1.rsp_rdata; assign o_rdata[2] = if2.rsp_rdata;
    assign o_err[0]   = if0.rsp_err;   assign o_err[1]   = if1.rsp_err;   assign o_err[2]   = if2.rsp_err;
    assign o_busy[0]  = if0.busy;      assign o_busy[1]  = if1.busy;      assign o_busy[2]  = if2.busy;

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .bus(if0.slave)
`ifdef DMEM_STATS_EN
        , .stat_loads(s_loads[0]), .stat_stores(s_stores[0]), .stat_errs(s_errs[0])
`endif
    );
    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset), .bus(if1.slave)
`ifdef DMEM_STATS_EN
        , .stat_loads(s_loads[1]), .stat_stores(s_stores[1]), .stat_errs(s_errs[1])
`endif
    );
    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .bus(if2.slave)
`ifdef DMEM_STATS_EN
        , .stat_loads(s_loads[2]), .stat_stores(s_stores[2]), .stat_errs(s_errs[2])
`endif
    );

    // Issues one request on instance k and reports latency (cycles from the accept
    // cycle to the response cycle), response data/error, and whether the strobe lasted one cycle.
    task automatic run_req(input int k, input logic wr, input logic [8:0] addr,
                           input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                           output int lat, output logic [31:0] rd, output logic er,
                           output logic pulse1);
        int n;
        lat = 0; rd = '0; er = 1'b0; pulse1 = 1'b0;
        @(negedge clk);
        d_wr[k] = wr; d_addr[k] = addr; d_wdata[k] = wd; d_size[k] = sz; d_uns[k] = uns;
        d_valid[k] = 1'b1;
        n = 0;
        while (!o_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready[k]) begin
            d_valid[k] = 1'b0;
            return;
        end
        @(negedge clk);
        d_valid[k] = 1'b0;
        d_wdata[k] = 32'h5A5A_5A5A;
        lat = 1;
        while (!o_rv[k] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!o_rv[k]) return;
        rd = o_rdata[k];
        er = o_err[k];
        @(negedge clk);
        pulse1 = !o_rv[k];
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_ready[k] !== 1'b0 || o_rv[k] !== 1'b0 || o_busy[k] !== 1'b0 ||
                o_err[k] !== 1'b0 || o_rdata[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: ready=%b rv=%b busy=%b err=%b rdata=%h, want all 0",
                         k, o_ready[k], o_rv[k], o_busy[k], o_err[k], o_rdata[k]);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (o_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL ready_at_release: got %b want 0", o_ready[1]);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_ready[k] !== 1'b1 || o_busy[k] !== 1'b0) begin
                errors++;
                $display("FAIL ready_after_release[%0d]: ready=%b busy=%b want 1/0",
                         k, o_ready[k], o_busy[k]);
            end
        end
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er, p1;
        run_req(1, 1'b1, 9'h010, 32'hDEADBEEF, 2'b10, 1'b0, lat, rd, er, p1);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'd0 || p1 !== 1'b1) begin
            errors++;
            $display("FAIL store_word: lat=%0d err=%b rdata=%h pulse1=%b want 2/0/0/1", lat, er, rd, p1);
        end
        run_req(1, 1'b0, 9'h010, 32'h0, 2'b10, 1'b0, lat, rd, er, p1);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF || p1 !== 1'b1) begin
            errors++;
            $display("FAIL load_word: lat=%0d err=%b rdata=%h pulse1=%b want 2/0/deadbeef/1", lat, er, rd, p1);
        end
    endtask

    task automatic test_byte_half();
        int lat; logic [31:0] rd; logic er, p1;
        run_req(1, 1'b1, 9'h013, 32'h0000_0080, 2'b00, 1'b0, lat, rd, er, p1);
        checks++;
        if (er !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL store_byte: err=%b lat=%0d want 0/2", er, lat);
        end
        run_req(1, 1'b0, 9'h013, 32'h0, 2'b00, 1'b0, lat, rd, er, p1);
        checks++;
        if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
            errors++;
            $display("FAIL load_byte_signed: rdata=%h err=%b want ffffff80/0", rd, er);
        end
        run_req(1, 1'b0, 9'h013, 32'h0, 2'b00, 1'b1, lat, rd, er, p1);
        checks++;
        if (rd !== 32'h00000080) begin
            errors++;
            $display("FAIL load_byte_unsigned: rdata=%h want 00000080", rd);
        end
        run_req(1, 1'b0, 9'h010, 32'h0, 2'b10, 1'b0, lat, rd, er, p1);
        checks++;
        if (rd !== 32'h80ADBEEF) begin
            errors++;
            $display("FAIL load_word_after_byte: rdata=%h want 80adbeef", rd);
        end
        run_req(1, 1'b0, 9'h012, 32'h0, 2'b01, 1'b0, lat, rd, er, p1);
        checks++;
        if (rd !== 32'hFFFF80AD) begin
            errors++;
            $display("FAIL load_half_signed: rdata=%h want ffff80ad", rd);
        end
        run_req(1, 1'b0, 9'h010, 32'h0, 2'b01, 1'b1, lat, rd, er, p1);
        checks++;
        if (rd !== 32'h0000BEEF) begin
            errors++;
            $display("FAIL load_half_unsigned: rdata=%h want 0000beef", rd);
        end
        run_req(1, 1'b0, 9'h011, 32'h0, 2'b00, 1'b0, lat, rd, er, p1);
        checks++;
        if (rd !== 32'hFFFFFFBE) begin
            errors++;
            $display("FAIL load_byte_lane1: rdata=%h want ffffffbe", rd);
        end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic er, p1;
        run_req(1, 1'b0, 9'h011, 32'h0, 2'b01, 1'b0, lat, rd, er, p1);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0 || lat !== 2 || p1 !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_half: err=%b rdata=%h lat=%0d pulse1=%b want 1/0/2/1", er, rd, lat, p1);
        end
        run_req(1, 1'b1, 9'h012, 32'h0000_0001, 2'b10, 1'b0, lat, rd, er, p1);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL misaligned_store: err=%b rdata=%h want 1/0", er, rd);
        end
        run_req(1, 1'b0, 9'h010, 32'h0, 2'b11, 1'b0, lat, rd, er, p1);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL reserved_size: err=%b rdata=%h want 1/0", er, rd);
        end
        run_req(1, 1'b0, 9'h010, 32'h0, 2'b10, 1'b0, lat, rd, er, p1);
        checks++;
        if (rd !== 32'h80ADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL ram_unchanged: rdata=%h err=%b want 80adbeef/0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er, p1;
        logic [4:0] exp_rdy;
        logic [4:0] exp_rv;
        exp_rdy = 5'b10101;
        exp_rv  = 5'b01010;
        run_req(0, 1'b1, 9'h000, 32'h1111_1111, 2'b10, 1'b0, lat, rd, er, p1);
        checks++;
        if (lat !== 1 || er !== 1'b0 || p1 !== 1'b1) begin
            errors++;
            $display("FAIL w0_store_latency: lat=%0d err=%b pulse1=%b want 1/0/1", lat, er, p1);
        end
        run_req(0, 1'b1, 9'h004, 32'h2222_2222, 2'b10, 1'b0, lat, rd, er, p1);
        @(negedge clk);
        d_wr[0] = 1'b0; d_addr[0] = 9'h000; d_size[0] = 2'b10; d_uns[0] = 1'b0;
        d_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (o_ready[0] !== exp_rdy[i] || o_rv[0] !== exp_rv[i]) begin
                errors++;
                $display("FAIL b2b_cycle%0d: ready=%b rsp_valid=%b want %b/%b",
                         i, o_ready[0], o_rv[0], exp_rdy[i], exp_rv[i]);
            end
            if (i == 1) begin
                checks++;
                if (o_rdata[0] !== 32'h1111_1111) begin
                    errors++;
                    $display("FAIL b2b_rdata0: got %h want 11111111", o_rdata[0]);
                end
                d_addr[0] = 9'h004;
            end
            if (i == 3) begin
                checks++;
                if (o_rdata[0] !== 32'h2222_2222) begin
                    errors++;
                    $display("FAIL b2b_rdata1: got %h want 22222222", o_rdata[0]);
                end
            end
            if (i == 4) d_valid[0] = 1'b0;
        end
    endtask

    task automatic test_reset_midop();
        int lat; logic [31:0] rd; logic er, p1;
        logic saw;
        run_req(2, 1'b1, 9'h020, 32'h1234_5678, 2'b10, 1'b0, lat, rd, er, p1);
        checks++;
        if (lat !== 4 || er !== 1'b0) begin
            errors++;
            $display("FAIL w3_store_latency: lat=%0d err=%b want 4/0", lat, er);
        end
        @(negedge clk);
        d_wr[2] = 1'b1; d_addr[2] = 9'h020; d_wdata[2] = 32'hCAFE_0000; d_size[2] = 2'b10;
        d_valid[2] = 1'b1;
        checks++;
        if (o_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL midop_ready_before: got %b want 1", o_ready[2]);
        end
        @(negedge clk);
        d_valid[2] = 1'b0;
        checks++;
        if (o_busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL midop_busy: got %b want 1", o_busy[2]);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (o_busy[2] !== 1'b0 || o_ready[2] !== 1'b0 || o_rv[2] !== 1'b0) begin
            errors++;
            $display("FAIL midop_in_reset: busy=%b ready=%b rv=%b want 0/0/0", o_busy[2], o_ready[2], o_rv[2]);
        end
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_rv[2] !== 1'b0) saw = 1'b1;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy[2] !== 1'b0 || o_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL midop_after_release: busy=%b ready=%b want 0/1", o_busy[2], o_ready[2]);
        end
        repeat (5) begin
            @(negedge clk);
            if (o_rv[2] !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL midop_no_response: rsp_valid seen=%b want 0", saw);
        end
        run_req(2, 1'b0, 9'h020, 32'h0, 2'b10, 1'b0, lat, rd, er, p1);
        checks++;
        if (rd !== 32'h1234_5678 || lat !== 4 || er !== 1'b0) begin
            errors++;
            $display("FAIL midop_prior_contents: rdata=%h lat=%0d err=%b want 12345678/4/0", rd, lat, er);
        end
    endtask

`ifdef DMEM_STATS_EN
    task automatic test_stats();
        int lat; logic [31:0] rd; logic er, p1;
        run_req(1, 1'b1, 9'h030, 32'hAAAA_5555, 2'b10, 1'b0, lat, rd, er, p1);
        run_req(1, 1'b1, 9'h031, 32'h0000_0077, 2'b00, 1'b0, lat, rd, er, p1);
        run_req(1, 1'b0, 9'h030, 32'h0, 2'b10, 1'b0, lat, rd, er, p1);
        checks++;
        if (rd !== 32'hAAAA_7755) begin
            errors++;
            $display("FAIL stats_byte_lane: rdata=%h want aaaa7755", rd);
        end
        run_req(1, 1'b0, 9'h010, 32'h0, 2'b10, 1'b0, lat, rd, er, p1);
        run_req(1, 1'b0, 9'h032, 32'h0, 2'b10, 1'b0, lat, rd, er, p1);
        run_req(1, 1'b0, 9'h013, 32'h0, 2'b00, 1'b1, lat, rd, er, p1);
        checks++;
        if (s_loads[1] !== 16'd3 || s_stores[1] !== 16'd2 || s_errs[1] !== 16'd1) begin
            errors++;
            $display("FAIL stats_counts: loads=%0d stores=%0d errs=%0d want 3/2/1",
                     s_loads[1], s_stores[1], s_errs[1]);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d_valid[k] = 1'b0; d_wr[k] = 1'b0; d_addr[k] = '0;
            d_wdata[k] = '0;   d_size[k] = 2'b00; d_uns[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        test_reset();
        test_word();
        test_byte_half();
        test_misaligned();
        test_back_to_back();
        test_reset_midop();
`ifdef DMEM_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
